pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised, handshaked pipeline-stage register that replaces the fixed per-stage registers (IF/ID and later) with one generic block. It carries a DATA_W-bit bundle (e.g. instruction + current PC + return PC) through a valid/ready handshake and provides an optional skid entry, so upstream back-pressure is a registered signal. It supports flush, which has priority over everything else and forces a configurable bubble value. It also keeps a saturating back-pressure counter for performance tracing.

## Interface
- DATA_W, 96, width of the carried bundle.
- BUBBLE, {DATA_W{1'b0}}, value driven on out_data_o when the stage holds nothing (reset, flush, drained).
- SKID, 1, 1 = two-entry skid (registered in_ready_o); 0 = single entry, combinational in_ready_o.
- CNT_W, 16, width of stall counter.

- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush: discard all held and incoming data.
- in_valid_i  in  1  upstream beat present.
- in_ready_o  out  1  stage can accept a beat this cycle.
- in_data_i  in  DATA_W  upstream bundle.
- out_valid_o  out  1  main entry holds a valid beat.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  main entry bundle (registered).
- occupancy_o  out  2  number of valid entries (0..2).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

## Operation
- Entries: main M (drives out_*) and skid S (present only when SKID=1). acc = in_valid_i & in_ready_o; snd = out_valid_o & out_ready_i.
- in_ready_o: SKID=1 → !S_valid (flop output, no input-to-output path). SKID=0 → !M_valid | out_ready_i.
- States: EMPTY (M and S invalid), ONE (M valid, S invalid), FULL (M and S valid; SKID=1 only).
- EMPTY: acc → M←in, ONE. Otherwise hold; out_data_o = BUBBLE.
- ONE:
  - snd & acc → M←in, stay ONE.
  - snd only → M invalid, M data←BUBBLE, EMPTY.
  - acc only → SKID=1: S←in, FULL. SKID=0: this case cannot occur.
  - Neither → hold.
- FULL: in_ready_o=0, so no acc. snd → M←S, S invalid, ONE. Otherwise hold M and S unchanged.
- Flush (highest priority, any state):
  - Next edge: M and S invalid, out_data_o←BUBBLE, state EMPTY.
  - A beat accepted in the flush cycle is dropped. Upstream treats it as consumed.
  - A beat sent in the flush cycle is still delivered downstream.
- Order is preserved: the S beat always follows the M beat.
- occupancy_o = M_valid + S_valid.
- stall_cnt_o increments by 1 in every cycle with out_valid_o & !out_ready_i, including the flush cycle. It sticks at 2^CNT_W−1. It is cleared only by reset.

## Timing
- Reset values:
  - out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0, stall_cnt_o=0.
  - in_ready_o=1 in both modes (SKID=0: !M_valid).
  - Internal S invalid, S data=BUBBLE.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on out_* after edge N; i.e. visible in cycle N+1.
- Throughput: 1 beat/cycle sustained while out_ready_i=1.
- SKID=1: in_ready_o falls one cycle after the first unabsorbed stall. It rises the cycle after S drains.
- Data stability: out_data_o and out_valid_o do not change while out_valid_o=1 and out_ready_i=0, unless flush_i=1.
- No combinational path from in_* to out_* in either mode. For SKID=0 only, there is a combinational path out_ready_i→in_ready_o.

## Test plan
- **Reset:** assert rst_i asynchronously mid-cycle with M valid (data 0x...A5) → out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0, stall_cnt_o=0 before the next edge.
- **Streaming:** SKID=1, DATA_W=8. Feed 0x01..0x10 with out_ready_i=1 → outputs 0x01..0x10 one per cycle, 1-cycle latency, in_ready_o constantly 1.
- **Back-pressure:**
  - Stimulus: SKID=1; with 0x11 in M, drop out_ready_i for 3 cycles while sending 0x22, 0x33.
  - While stalled: 0x22 lands in S, in_ready_o=0 next cycle, 0x33 is held upstream, occupancy_o=2, out_data_o stays 0x11, stall_cnt_o=3.
  - On release: 0x11, 0x22, 0x33 in order.
- **Flush in FULL:** state FULL (0x44 in M, 0x55 in S), assert flush_i with in_valid_i=1 (data 0x66) → next cycle EMPTY, out_valid_o=0, out_data_o=BUBBLE, 0x66 never appears.
- **SKID=0:**
  - M holds 0x77, out_ready_i=0 → in_ready_o=0.
  - Raise out_ready_i with 0x88 offered → in_ready_o=1 in the same cycle, 0x88 on out_data_o next cycle.
- **Counter saturation:** CNT_W=4, hold out_valid_o=1 with out_ready_i=0 for 20 cycles → stall_cnt_o reaches 0xF and stays 0xF.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Generic handshaked pipeline-stage register. Carries a DATA_W-bit
//            bundle through a valid/ready handshake, with an optional skid
//            entry so that in_ready_o is a flop output. Flush has priority
//            over everything and forces the BUBBLE value. A saturating
//            counter tracks cycles spent stalled by downstream.
// Ports    : clk_i        clock, rising edge
//            rst_i        asynchronous active-high reset
//            flush_i      synchronous flush of held and incoming data
//            in_valid_i   upstream beat present
//            in_ready_o   stage can accept a beat this cycle
//            in_data_i    upstream bundle
//            out_valid_o  main entry holds a valid beat
//            out_ready_i  downstream accepts this cycle
//            out_data_o   main entry bundle (registered)
//            occupancy_o  number of valid entries (0..2)
//            stall_cnt_o  saturating count of valid-but-not-ready cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                SKID   = 1,
  parameter int                CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic [DATA_W-1:0]  s_data_q, s_data_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic m_valid;
  logic s_valid;
  logic acc;
  logic snd;

  assign m_valid = (state_q != ST_EMPTY);
  assign s_valid = (state_q == ST_FULL);

  generate
    if (SKID != 0) begin : g_ready_skid
      // Ready depends only on state: no path from out_ready_i.
      assign in_ready_o = !s_valid;
    end else begin : g_ready_comb
      // Single entry: can refill in the same cycle the beat leaves.
      assign in_ready_o = !m_valid || out_ready_i;
    end
  endgenerate

  assign acc = in_valid_i && in_ready_o;
  assign snd = m_valid && out_ready_i;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      // Sent beat still leaves this cycle; accepted beat is dropped.
      state_d  = ST_EMPTY;
      m_data_d = BUBBLE;
      s_data_d = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            m_data_d = in_data_i;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (snd && acc) begin
            m_data_d = in_data_i;
          end else if (snd) begin
            m_data_d = BUBBLE;
            state_d  = ST_EMPTY;
          end else if (acc && (SKID != 0)) begin
            // Stall not absorbed by M: park the new beat behind it.
            s_data_d = in_data_i;
            state_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (snd) begin
            m_data_d = s_data_q;
            s_data_d = BUBBLE;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          m_data_d = BUBBLE;
          s_data_d = BUBBLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      m_data_q    <= BUBBLE;
      s_data_q    <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = m_valid;
  assign out_data_o  = m_data_q;
  assign occupancy_o = {1'b0, m_valid} + {1'b0, s_valid};
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
